// File: rtl/codificador_entrada_pkg.sv
// Shared definitions for the input encoder: bit positions of the one-hot
// Entrada word, the start code, pad-FSM state encodings and a clog2 helper.
package codificador_entrada_pkg;

    localparam int BIT_INICIO   = 0;
    localparam int BIT_ESTATICA = 1;
    localparam int BIT_BANDA1   = 2;
    localparam int BIT_BANDA2   = 3;
    localparam int BIT_BANDA3   = 4;
    localparam int BIT_BANDA4   = 5;
    localparam int BIT_BANDA5   = 6;

    localparam logic [6:0] CODIGO_INICIO = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BANDA = 2'd1,
        ST_GAP   = 2'd2
    } estado_t;

    // Bits needed to represent values 0..valor-1 (ceil(log2(valor))).
    function automatic int clog2(input int valor);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < valor) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/codificador_entrada_antirrebote.sv
// Two-flop synchronizer followed by a debouncer for one raw asynchronous input.
// Ports:
//   clk   system clock
//   reset asynchronous active-low reset
//   din   raw asynchronous input
//   dout  debounced level
//   sube  one-cycle pulse, high during the first cycle dout is 1 after a rise
module antirrebote
    import codificador_entrada_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic sube
);

    localparam int CW = clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    logic          sinc1_q, sinc1_d;
    logic          sinc2_q, sinc2_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          nivel_q, nivel_d;
    logic          sube_q, sube_d;

    always_comb begin
        sinc1_d = din;
        sinc2_d = sinc1_q;
        cnt_d   = '0;
        nivel_d = nivel_q;
        sube_d  = 1'b0;
        // The counter only runs while the synchronized value disagrees with
        // the debounced level; the DEB_CYCLES-th disagreeing sample flips it.
        if (sinc2_q != nivel_q) begin
            if (cnt_q == CNT_MAX) begin
                nivel_d = sinc2_q;
                sube_d  = sinc2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sinc1_q <= 1'b0;
            sinc2_q <= 1'b0;
            cnt_q   <= '0;
            nivel_q <= 1'b0;
            sube_q  <= 1'b0;
        end else begin
            sinc1_q <= sinc1_d;
            sinc2_q <= sinc2_d;
            cnt_q   <= cnt_d;
            nivel_q <= nivel_d;
            sube_q  <= sube_d;
        end
    end

    assign dout = nivel_q;
    assign sube = sube_q;

endmodule

// File: rtl/codificador_entrada.sv
// Producer of the 7-bit one-hot Entrada command word: conditions the start
// button, static-band switch and five drum pads, then encodes them.
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   start_btn    raw start button
//   estatica_btn raw static-band switch
//   pad[4:0]     raw drum pads, pad[0] = band 1 ... pad[4] = band 5
//   Entrada      registered one-hot command word (bit0 start, bit1 static, bits 2..6 pads)
//   banda_idx    registered latched pad, 0 = none, 1..5 = band
//   golpe        registered one-cycle pulse on the cycle a pad is latched
//
// state | meaning
// IDLE  | no pad latched; start pulse may be emitted, lowest high pad latched
// BANDA | pad k shown on Entrada for at least HOLD_CYCLES, until it releases
// GAP   | one cycle with all pad bits low before returning to IDLE
module codificador_entrada
    import codificador_entrada_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int HOLD_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_btn,
    input  logic       estatica_btn,
    input  logic [4:0] pad,
    output logic [6:0] Entrada,
    output logic [2:0] banda_idx,
    output logic       golpe
);

    localparam int HW = clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);

    logic [6:0] crudo;
    logic [6:0] nivel;
    logic [6:0] sube_w;
    logic       senal_unused;

    assign crudo = {pad, estatica_btn, start_btn};

    for (genvar i = 0; i < 7; i++) begin : g_antirrebote
        antirrebote #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_antirrebote (
            .clk  (clk),
            .reset(reset),
            .din  (crudo[i]),
            .dout (nivel[i]),
            .sube (sube_w[i])
        );
    end

    // Only the start edge and the other inputs' levels are consumed.
    assign senal_unused = ^{nivel[BIT_INICIO], sube_w[6:1]};

    estado_t       state_q, state_d;
    logic [2:0]    pad_k_q, pad_k_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          start_pend_q, start_pend_d;
    logic [6:0]    entrada_q, entrada_d;
    logic [2:0]    banda_idx_q, banda_idx_d;
    logic          golpe_q, golpe_d;

    logic [4:0] pads_niv;
    logic [2:0] pad_sel;
    logic       pad_hit;
    logic       start_req;
    logic       emite_inicio;
    logic       estado_legal;

    assign pads_niv = nivel[BIT_BANDA5:BIT_BANDA1];

    always_comb begin
        state_d      = state_q;
        pad_k_d      = pad_k_q;
        hold_d       = hold_q;
        entrada_d    = '0;
        banda_idx_d  = 3'd0;
        golpe_d      = 1'b0;

        // Walk downwards so the lowest-index high pad wins.
        pad_sel = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (pads_niv[i]) begin
                pad_sel = 3'(i);
            end
        end
        pad_hit = |pads_niv;

        estado_legal = (state_q == ST_IDLE) || (state_q == ST_BANDA) ||
                       (state_q == ST_GAP);

        // A start edge seen while a pulse is already pending merges into it.
        start_req    = start_pend_q | sube_w[BIT_INICIO];
        emite_inicio = start_req && (state_q == ST_IDLE) && !nivel[BIT_ESTATICA];
        start_pend_d = start_req && !emite_inicio;

        case (state_q)
            ST_IDLE: begin
                if (emite_inicio) begin
                    entrada_d = CODIGO_INICIO;
                end else if (pad_hit) begin
                    state_d = ST_BANDA;
                    pad_k_d = pad_sel;
                    hold_d  = '0;
                    golpe_d = 1'b1;
                end
            end
            ST_BANDA: begin
                if (hold_q == HOLD_MAX) begin
                    if (!pads_niv[pad_k_q]) begin
                        state_d = ST_GAP;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d == ST_BANDA) begin
            entrada_d[BIT_BANDA5:BIT_BANDA1] = 5'b00001 << pad_k_d;
            banda_idx_d = pad_k_d + 3'd1;
        end
        if (!emite_inicio && estado_legal) begin
            entrada_d[BIT_ESTATICA] = nivel[BIT_ESTATICA];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pad_k_q      <= 3'd0;
            hold_q       <= '0;
            start_pend_q <= 1'b0;
            entrada_q    <= '0;
            banda_idx_q  <= 3'd0;
            golpe_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pad_k_q      <= pad_k_d;
            hold_q       <= hold_d;
            start_pend_q <= start_pend_d;
            entrada_q    <= entrada_d;
            banda_idx_q  <= banda_idx_d;
            golpe_q      <= golpe_d;
        end
    end

    assign Entrada   = entrada_q;
    assign banda_idx = banda_idx_q;
    assign golpe     = golpe_q;

endmodule

// File: tb/tb_codificador_entrada.sv
// Scoreboard bench for codificador_entrada (DEB_CYCLES=4, HOLD_CYCLES=3).
// A behavioural model predicts every change of {Entrada, banda_idx, golpe}
// with its cycle number; a monitor pops and compares on each DUT change.
module tb_codificador_entrada;

    localparam int DEB  = 4;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start_btn = 1'b0;
    logic       estatica_btn = 1'b0;
    logic [4:0] pad = 5'b0;
    logic [6:0] Entrada;
    logic [2:0] banda_idx;
    logic       golpe;

    codificador_entrada #(
        .DEB_CYCLES (DEB),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_btn   (start_btn),
        .estatica_btn(estatica_btn),
        .pad         (pad),
        .Entrada     (Entrada),
        .banda_idx   (banda_idx),
        .golpe       (golpe)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] e;
        logic [2:0] idx;
        logic       g;
    } salida_t;

    typedef struct {
        int unsigned stamp;
        salida_t     v;
    } esperado_t;

    esperado_t   exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int          pulsos_inicio = 0;

    // ---------------- reference model ----------------
    bit [6:0] hist[$];
    bit [6:0] lvl;
    bit [6:0] rose;
    int       run[7];
    bit       pend;
    int       active;
    int       shown;
    bit       gap;
    salida_t  m_out = '0;
    salida_t  m_prev = '0;

    function automatic void model_reset();
        hist.delete();
        hist.push_back(7'b0);
        hist.push_back(7'b0);
        lvl = '0;
        rose = '0;
        for (int i = 0; i < 7; i++) run[i] = 0;
        pend = 1'b0;
        active = -1;
        shown = 0;
        gap = 1'b0;
        m_out = '0;
    endfunction

    function automatic void model_step(input bit [6:0] raw);
        bit [6:0] seen;
        bit       req;
        bit       emit;
        bit       g;
        int       k;
        seen = hist.pop_front();
        hist.push_back(raw);

        req  = pend || rose[0];
        emit = req && (active < 0) && !gap && !lvl[1];
        pend = req && !emit;
        g = 1'b0;
        if (!emit) begin
            if (gap) begin
                gap = 1'b0;
            end else if (active < 0) begin
                k = -1;
                for (int i = 4; i >= 0; i--) if (lvl[2+i]) k = i;
                if (k >= 0) begin
                    active = k;
                    shown = 1;
                    g = 1'b1;
                end
            end else if (shown >= HOLD && !lvl[2+active]) begin
                active = -1;
                gap = 1'b1;
            end else begin
                shown++;
            end
        end

        m_out = '0;
        if (emit) begin
            m_out.e[0] = 1'b1;
        end else begin
            m_out.e[1] = lvl[1];
            if (active >= 0) m_out.e[2+active] = 1'b1;
        end
        m_out.idx = (active >= 0) ? 3'(active + 1) : 3'd0;
        m_out.g = g;

        // Debounce: a level changes on the DEB-th consecutive differing
        // synchronized sample (samples are the raw values two edges old).
        for (int i = 0; i < 7; i++) begin
            rose[i] = 1'b0;
            if (seen[i] != lvl[i]) run[i]++;
            else run[i] = 0;
            if (run[i] == DEB) begin
                lvl[i] = ~lvl[i];
                run[i] = 0;
                rose[i] = lvl[i];
            end
        end
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!reset) model_reset();
        else model_step({pad, estatica_btn, start_btn});
        if (m_out != m_prev) begin
            exp_q.push_back('{cyc, m_out});
            m_prev = m_out;
        end
    end

    // ---------------- monitor ----------------
    salida_t dut_prev = '0;
    logic    golpe_prev = 1'b0;

    always @(posedge clk) begin
        salida_t   cur;
        esperado_t ex;
        #1;
        cur = {Entrada, banda_idx, golpe};

        checks++;
        if ($countones(Entrada[6:2]) > 1 || (Entrada[0] && Entrada[6:1] != 6'b0) ||
            (golpe && golpe_prev)) begin
            failures++;
            $display("FAIL invariant cyc=%0d Entrada=%b golpe=%0b prev_golpe=%0b required one-hot pads, exclusive start, no back-to-back golpe",
                     cyc, Entrada, golpe, golpe_prev);
        end
        golpe_prev = golpe;
        if (Entrada == 7'b0000001) pulsos_inicio++;

        if (cur != dut_prev) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got E=%b idx=%0d g=%0b required no change",
                         cyc, cur.e, cur.idx, cur.g);
            end else begin
                ex = exp_q.pop_front();
                if (ex.v != cur || ex.stamp != cyc) begin
                    failures++;
                    $display("FAIL scoreboard cyc=%0d got E=%b idx=%0d g=%0b required E=%b idx=%0d g=%0b at cyc=%0d",
                             cyc, cur.e, cur.idx, cur.g, ex.v.e, ex.v.idx, ex.v.g, ex.stamp);
                end
            end
            dut_prev = cur;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_pulsos(input string nombre, input int req);
        checks++;
        if (pulsos_inicio != req) begin
            failures++;
            $display("FAIL %s start_pulse_cycles got=%0d required=%0d", nombre, pulsos_inicio, req);
        end
    endtask

    initial begin
        tick(3);
        reset = 1'b1;
        tick(5);

        // Start held 20 cycles: exactly one pulse.
        pulsos_inicio = 0;
        start_btn = 1'b1;
        tick(20);
        start_btn = 1'b0;
        tick(15);
        check_pulsos("start_held", 1);

        // pad[0] bounces, then a short stable press.
        for (int i = 0; i < 3; i++) begin
            pad[0] = 1'b1; tick(1);
            pad[0] = 1'b0; tick(1);
        end
        tick(6);
        pad[0] = 1'b1; tick(DEB);
        pad[0] = 1'b0; tick(20);

        // pad[1] and pad[3] together; then pad[1] releases.
        pad = 5'b01010; tick(15);
        pad = 5'b01000; tick(20);
        pad = 5'b00000; tick(15);

        // Static with pad[4]; start pressed meanwhile is deferred.
        pulsos_inicio = 0;
        estatica_btn = 1'b1; tick(10);
        pad[4] = 1'b1; tick(10);
        start_btn = 1'b1; tick(8);
        start_btn = 1'b0; pad = 5'b0; tick(10);
        check_pulsos("start_deferred_none_yet", 0);
        estatica_btn = 1'b0; tick(20);
        check_pulsos("start_deferred", 1);

        // Start and pad[2] debounce on the same edge.
        start_btn = 1'b1; pad[2] = 1'b1; tick(15);
        start_btn = 1'b0; pad[2] = 1'b0; tick(20);

        // Reset mid-BANDA with pad[2] held.
        pad[2] = 1'b1; tick(9);
        reset = 1'b0;
        #1;
        checks++;
        if (Entrada !== 7'b0 || banda_idx !== 3'd0 || golpe !== 1'b0) begin
            failures++;
            $display("FAIL reset_immediate got E=%b idx=%0d g=%0b required all zero", Entrada, banda_idx, golpe);
        end
        tick(2);
        reset = 1'b1; tick(15);
        pad[2] = 1'b0; tick(20);

        // Randomized phase with toggles (bounce-like) and rare resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 799) == 0) begin
                reset = 1'b0;
                tick($urandom_range(1, 2));
                reset = 1'b1;
            end
            if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 29) == 0) estatica_btn = ~estatica_btn;
            for (int p = 0; p < 5; p++) begin
                if ($urandom_range(0, 13) == 0) pad[p] = ~pad[p];
            end
            tick(1);
        end

        start_btn = 1'b0; estatica_btn = 1'b0; pad = 5'b0;
        tick(40);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending_expected got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
